// File: rtl/pbuf_bank.sv
// Programmable output buffer bank: a serial shadow chain is committed atomically to the
// active per-channel mode config, with length checking and serial readback.

module pbuf_lane (
  input  logic       prog_clk,
  input  logic       prog_rst,
  input  logic [1:0] i_mode,
  input  logic       i_in,
  output logic       o_drv,
  output logic       o_oe
);
  logic r_q;

  always_ff @(posedge prog_clk or posedge prog_rst) begin
    if (prog_rst) r_q <= 1'b0;
    else          r_q <= i_in;
  end

  always_comb begin
    o_drv = 1'b0;
    o_oe  = |i_mode;
    case (i_mode)
      2'b01:   o_drv = i_in;
      2'b10:   o_drv = ~i_in;
      2'b11:   o_drv = r_q;
      default: o_drv = 1'b0;
    endcase
  end
endmodule

module pbuf_bank #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(2*WIDTH+2)
) (
  input  logic             prog_clk,
  input  logic             prog_rst,
  input  logic             prog_en,
  input  logic             prog_in,
  input  logic             prog_commit,
  output logic             prog_out,
  output logic             prog_err,
  output logic             cfg_valid,
  input  logic [WIDTH-1:0] in,
  output wire  [WIDTH-1:0] out
);
  localparam int LEN = 2*WIDTH;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LEN);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(LEN+1);

  logic [LEN-1:0]   r_sh, r_act;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] w_drv, w_oe;

  // Commit takes priority over shift; the length check sees the pre-edge count.
  always_ff @(posedge prog_clk or posedge prog_rst) begin
    if (prog_rst) begin
      r_sh      <= '0;
      r_act     <= '0;
      r_cnt     <= '0;
      prog_err  <= 1'b0;
      cfg_valid <= 1'b0;
    end else if (prog_commit) begin
      r_cnt <= '0;
      if (r_cnt == CNT_FULL) begin
        r_act     <= r_sh;
        cfg_valid <= 1'b1;
        prog_err  <= 1'b0;
      end else begin
        prog_err  <= 1'b1;
      end
    end else if (prog_en) begin
      r_sh <= {r_sh[LEN-2:0], prog_in};
      if (r_cnt != CNT_SAT) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign prog_out = r_sh[LEN-1];

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    pbuf_lane u_lane (
      .prog_clk (prog_clk),
      .prog_rst (prog_rst),
      .i_mode   (r_act[2*g+1:2*g]),
      .i_in     (in[g]),
      .o_drv    (w_drv[g]),
      .o_oe     (w_oe[g])
    );
    assign out[g] = w_oe[g] ? w_drv[g] : 1'bz;
  end
endmodule

// File: tb/tb_pbuf_bank.sv
// Randomized bench for pbuf_bank (WIDTH=4) against a queue-based behavioural model,
// plus directed scenarios with literal expectations.

module tb_pbuf_bank;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0, pin = 1'b0, cm = 1'b0;
  logic [W-1:0] din = '0;
  logic         pout, perr, cval;
  wire  [W-1:0] dout;

  int checks = 0;
  int errors = 0;

  // Model: last 2W shifted bits (oldest first), unsaturated-then-clamped count, modes.
  bit         sh_q[$];
  int         m_cnt;
  logic [1:0] m_mode[W];
  bit         m_err, m_val;
  logic [W-1:0] m_rprev;

  pbuf_bank #(.WIDTH(W)) dut (
    .prog_clk(clk), .prog_rst(rst), .prog_en(en), .prog_in(pin),
    .prog_commit(cm), .prog_out(pout), .prog_err(perr), .cfg_valid(cval),
    .in(din), .out(dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  // A released channel must never actively drive a 1.
  task automatic chk_z(input string name, input logic act);
    checks++;
    if (act === 1'b1) begin
      errors++;
      $display("FAIL %s actual=%b required=z t=%0t", name, act, $time);
    end
  endtask

  task automatic model_reset();
    sh_q = {};
    for (int k = 0; k < 2*W; k++) sh_q.push_back(1'b0);
    m_cnt = 0; m_err = 0; m_val = 0; m_rprev = '0;
    for (int i = 0; i < W; i++) m_mode[i] = 2'b00;
  endtask

  task automatic model_edge(input bit e, input bit b, input bit c, input logic [W-1:0] d);
    if (c) begin
      if (m_cnt == 2*W) begin
        // SH[j] is sh_q[2W-1-j]
        for (int i = 0; i < W; i++) m_mode[i] = {sh_q[2*W-2-2*i], sh_q[2*W-1-2*i]};
        m_val = 1; m_err = 0;
      end else m_err = 1;
      m_cnt = 0;
    end else if (e) begin
      sh_q.push_back(b);
      void'(sh_q.pop_front());
      m_cnt = (m_cnt < 2*W+1) ? m_cnt + 1 : 2*W+1;
    end
    m_rprev = d;
  endtask

  task automatic check_all();
    chk("prog_out", pout, sh_q[0]);
    chk("prog_err", perr, m_err);
    chk("cfg_valid", cval, m_val);
    for (int i = 0; i < W; i++) begin
      case (m_mode[i])
        2'b00: chk_z($sformatf("out%0d_z", i), dout[i]);
        2'b01: chk($sformatf("out%0d_pass", i), dout[i], din[i]);
        2'b10: chk($sformatf("out%0d_inv", i), dout[i], ~din[i]);
        default: chk($sformatf("out%0d_reg", i), dout[i], m_rprev[i]);
      endcase
    end
  endtask

  // Inputs change just after the falling edge; check sees new comb inputs vs registered state.
  task automatic cyc(input bit e, input bit b, input bit c, input logic [W-1:0] d);
    en = e; pin = b; cm = c; din = d;
    #1 check_all();
    @(posedge clk);
    model_edge(e, b, c, d);
    @(negedge clk);
  endtask

  task automatic shift_n(input logic [15:0] v, input int n);
    for (int k = n-1; k >= 0; k--) cyc(1'b1, v[k], 1'b0, W'($urandom));
  endtask

  task automatic commit();
    cyc(1'b0, 1'b0, 1'b1, W'($urandom));
  endtask

  initial begin
    logic [7:0] a5;
    int n;
    model_reset();
    @(negedge clk);
    rst = 1'b1; din = 4'b1010;
    #1;
    chk("rst_prog_out", pout, 1'b0);
    chk("rst_prog_err", perr, 1'b0);
    chk("rst_cfg_valid", cval, 1'b0);
    for (int i = 0; i < W; i++) chk_z("rst_out_z", dout[i]);
    @(negedge clk);
    rst = 1'b0;

    // SH=11100100: ch0 z, ch1 pass, ch2 invert, ch3 registered
    shift_n(16'h00E4, 8);
    cyc(1'b0, 1'b0, 1'b1, 4'b1000);
    en = 0; cm = 0; din = 4'b0110;
    #1;
    chk_z("s2_out0", dout[0]);
    chk("s2_out1", dout[1], 1'b1);
    chk("s2_out2", dout[2], 1'b0);
    chk("s2_out3", dout[3], 1'b1);
    chk("s2_valid", cval, 1'b1);
    chk("s2_err", perr, 1'b0);
    @(posedge clk); model_edge(0, 0, 0, din); @(negedge clk);

    // short shift is rejected, full 0x55 accepted
    shift_n(16'h001F, 5);
    commit();
    cyc(0, 0, 0, 4'b1001);
    chk("s3_short_err", perr, 1'b1);
    chk("s3_out1_kept", dout[1], 1'b0);
    shift_n(16'h0055, 8);
    commit();
    cyc(0, 0, 0, 4'b0011);
    chk("s3_ok_err", perr, 1'b0);
    for (int i = 0; i < W; i++) chk("s3_pass", dout[i], din[i]);

    // over-shift, then shift+commit together
    shift_n(16'h01AA, 9);
    commit();
    cyc(0, 0, 0, 4'b1100);
    chk("s4_over_err", perr, 1'b1);
    chk("s4_act_kept", dout[3], 1'b1);
    shift_n(16'h00AA, 8);
    cyc(1'b1, 1'b1, 1'b1, 4'b0101);
    cyc(0, 0, 0, 4'b0101);
    chk("s4_simul_err", perr, 1'b0);
    chk("s4_simul_inv", dout[0], 1'b0);

    // serial readback of 0xA5
    a5 = 8'hA5;
    shift_n(16'h00A5, 8);
    chk("s5_out_b7", pout, a5[7]);
    for (int k = 6; k >= 0; k--) begin
      cyc(1'b1, 1'b0, 1'b0, W'($urandom));
      chk("s5_readback", pout, a5[k]);
    end
    cyc(1'b1, 1'b0, 1'b0, W'($urandom));

    // all registered: out lags in by one edge
    shift_n(16'h00FF, 8);
    commit();
    cyc(0, 0, 0, 4'b1111);
    din = 4'b0000;
    #1;
    for (int i = 0; i < W; i++) chk("s6_lag", dout[i], 1'b1);
    @(posedge clk); model_edge(0, 0, 0, din); @(negedge clk);
    for (int k = 0; k < 6; k++) cyc(0, 0, 0, (k % 2) ? 4'b1010 : 4'b0101);

    // async reset mid-shift
    shift_n(16'h0005, 3);
    en = 1'b1; pin = 1'b1;
    rst = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < W; i++) chk_z("s6_rst_z", dout[i]);
    chk("s6_rst_valid", cval, 1'b0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    shift_n(16'h00B4, 8);
    commit();
    cyc(0, 0, 0, 4'b0000);
    chk("s6_after_rst_err", perr, 1'b0);
    chk("s6_after_rst_valid", cval, 1'b1);

    // randomized: mixed lengths, gaps, simultaneous and back-to-back commits
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 6))
        0: n = 5; 1: n = 7; 2: n = 9; 3: n = 11;
        default: n = 8;
      endcase
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 4) == 0) cyc(0, 0, 0, W'($urandom));
        cyc(1'b1, 1'($urandom), 1'b0, W'($urandom));
      end
      cyc(1'($urandom_range(0, 3) == 0), 1'($urandom), 1'b1, W'($urandom));
      if ($urandom_range(0, 9) == 0) commit();
      for (int k = 0; k < 3; k++) cyc(0, 0, 0, W'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
